fixed_order_selector: RTL
=========================

# fixed_order_selector

Block-level controller that selects the fixed-LPC predictor order (0–4) for each audio block before the fixed encoders run. It takes one block of 16-bit samples and computes the order-0 to order-4 fixed residuals with a difference chain. It accumulates the absolute residual of each order over the block and reports the order with the smallest sum. The downstream encoder stage uses that result to pick which fixed encoder's residual stream it emits.

## Interface
- `BLOCK_SIZE`, default 4096: samples per full block; must be ≥ 5.
- `SUM_W`, default 32: accumulator width, equal to 20 + clog2(`BLOCK_SIZE`).
- `iClock` input 1: clock; all state updates on the rising edge.
- `iReset_n` input 1: reset, asynchronous and active-low.
- `iValid` input 1: `iSample` is valid this cycle.
- `iSample` input 16: signed PCM sample.
- `iLast` input 1: qualified by `iValid`; marks the final sample of a short block.
- `oReady` output 1: block accepts a sample this cycle. A sample is accepted only when `iValid && oReady`.
- `oValid` output 1: one-cycle pulse; `oOrder` and `oSum` are valid.
- `oOrder` output 3: selected order, 0..4.
- `oSum` output SUM_W: unsigned sum of |residual| for `oOrder`.

## Operation
- **FSM states:** ACCUM, DRAIN, COMPARE, DONE. The reset state is ACCUM.
- **ACCUM:**
  - `oReady`=1.
  - Every accepted sample increments `sample_cnt`, which starts at 0 per block.
  - Leave ACCUM on the accepting edge of the block's last sample. The last sample is sample `BLOCK_SIZE`-1 or any sample with `iLast`=1.
  - `iLast` on sample index `BLOCK_SIZE`-1 is redundant and legal.
- **Difference chain, stage 1 (registered):**
  - e0=x.
  - ek = e(k-1) − e(k-1)_prev for k=1..4.
  - All terms are signed 20-bit, so no overflow is possible.
  - The `_prev` registers are cleared at block start; there is no inter-block history.
- **Stage 2 (registered):** `sum[k]` += |ek|, but only when the sample index ≥ k. The first k samples of a block are warm-up for order k.
- **DRAIN:** 2 cycles. `oReady`=0; the pipeline empties.
- **COMPARE:**
  - 5 cycles, scanning idx 0..4 sequentially.
  - Order k is eligible iff block length > k. Order 0 is always eligible.
  - A candidate replaces the best only if it is eligible and its sum is strictly less. Ties therefore resolve to the lower order.
- **DONE:**
  - 1 cycle with `oValid`=1. `oOrder` and `oSum` are registered and held until the next DONE.
  - On exit, clear the sums, `_prev` registers and `sample_cnt`, and return to ACCUM.
- **Width rule:** |e4| ≤ 524280 and the sum is < 2^SUM_W for a full block, so there is no saturation logic.

## Timing
- **Reset** (asynchronous on `iReset_n` low):
  - `oReady`=1 on release, `oValid`=0, `oOrder`=0, `oSum`=0.
  - All sums, counters and chain registers are 0; state is ACCUM.
- **Reset mid-block:** the partial block is discarded. No `oValid` is produced for it.
- **Latency:** the last sample is accepted at edge E0. `oValid` is high for exactly the cycle after edge E7.
- **Backpressure:** `oReady`=0 from E0 until the edge ending DONE, i.e. 8 cycles. It is 1 again in the cycle after `oValid`.
- **Input while not ready:** `iValid` while `oReady`=0 is ignored. The source must hold the sample.
- **Input gaps:** `iValid` gaps in ACCUM are allowed. The chain and accumulators advance only on accepted samples.
- **Short blocks:** a block of length 1 (`iLast` on the first sample) yields order 0 with `oSum`=|x0|.

## Structure
- Shared package `flac_enc_pkg` holds:
  - `ORDER_MAX`=4.
  - `RES_W`=20.
  - The FSM state typedef/encoding (ACCUM, DRAIN, COMPARE, DONE).
- One sub-module, `fixed_residual_chain`:
  - Contains the stage-1 difference registers e0..e4 plus the clear input.
  - Is reused by the fixed encoders.
- The controller (FSM, counters, accumulators, compare) stays in `fixed_order_selector`.

## Test plan
- **Constant block:** 4096 samples of value 100 → `oOrder`=1, `oSum`=0. Orders 2–4 tie at 0 and the lower order wins.
- **Ramp:** x[n]=n for n=0..4095 → `oOrder`=2, `oSum`=0. Check internal `sum[1]`=4095.
- **Alternating extremes:** 32767/−32768 × 2048 → `oOrder`=0, `oSum`=134215680.
  - Also check `sum[4]`=4092×524280 with no wrap.
- **Short block:** samples 0, 10, 20 with `iLast` on 20 → orders 3 and 4 ineligible.
  - Expect `oOrder`=2, `oSum`=0, with `oValid` 7 cycles after the accept.
  - Confirm `oReady`=0 throughout.
- **Backpressure and gaps:** random `iValid` gaps during a ramp block → same result as the gap-free ramp.
  - A sample presented while `oReady`=0 is not consumed.
- **Reset mid-block:** pulse `iReset_n` low after 1000 samples, then send a full constant block.
  - Expect no `oValid` before the new block completes.
  - Expect `oOrder`=1, `oSum`=0, and outputs 0 during and after reset.

Source files
------------

// File: rtl/flac_enc_pkg.sv
// Shared definitions for the fixed-LPC encoder blocks: residual widths,
// maximum fixed order and the order-selector state encoding.
package flac_enc_pkg;

  localparam int ORDER_MAX = 4;
  localparam int RES_W     = 20;
  localparam int SAMPLE_W  = 16;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    DRAIN   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } sel_state_e;

  // Magnitude of a residual; the most negative value still fits unsigned.
  function automatic logic [RES_W-1:0] abs_res(input logic signed [RES_W-1:0] v);
    return v[RES_W-1] ? RES_W'(-v) : RES_W'(v);
  endfunction

endpackage

// File: rtl/fixed_order_selector_if.sv
// Sample-in / decision-out bus of the fixed order selector.
interface fixed_order_selector_if #(
  parameter int SUM_W = 32
);
  import flac_enc_pkg::*;

  logic                iValid;
  logic [SAMPLE_W-1:0] iSample;
  logic                iLast;
  logic                oReady;
  logic                oValid;
  logic [2:0]          oOrder;
  logic [SUM_W-1:0]    oSum;

  modport master (
    output iValid, iSample, iLast,
    input  oReady, oValid, oOrder, oSum
  );

  modport slave (
    input  iValid, iSample, iLast,
    output oReady, oValid, oOrder, oSum
  );

endinterface

// File: rtl/fixed_residual_chain.sv
// Registered difference chain producing the order-0..4 fixed residuals of the
// most recent sample; history is zero after reset or clear.
module fixed_residual_chain
  import flac_enc_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       valid_i,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  output logic signed [RES_W-1:0]    res_o [ORDER_MAX+1]
);

  logic signed [RES_W-1:0] res_q [ORDER_MAX+1];
  logic signed [RES_W-1:0] res_d [ORDER_MAX+1];

  // The registered e(k) of the previous sample is exactly e(k)_prev.
  always_comb begin : chain_comb
    logic signed [RES_W-1:0] acc;
    // NOTE: blocking assignments in combinational logic; acc must carry each
    // stage's value into the next stage within the same evaluation.
    acc      = {{(RES_W-SAMPLE_W){sample_i[SAMPLE_W-1]}}, sample_i};
    res_d[0] = acc;
    for (int k = 1; k <= ORDER_MAX; k++) begin
      acc      = acc - res_q[k-1];
      res_d[k] = acc;
    end
  end

  // NOTE: non-blocking assignments for registers so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= ORDER_MAX; k++) res_q[k] <= '0;
    end else if (clear_i) begin
      for (int k = 0; k <= ORDER_MAX; k++) res_q[k] <= '0;
    end else if (valid_i) begin
      for (int k = 0; k <= ORDER_MAX; k++) res_q[k] <= res_d[k];
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/fixed_order_selector.sv
// Accumulates |residual| per fixed order over one block and reports the
// order with the smallest sum (ties resolve to the lower order).
module fixed_order_selector
  import flac_enc_pkg::*;
#(
  parameter int BLOCK_SIZE = 4096,
  parameter int SUM_W      = 32
) (
  input  logic                  iClock,
  input  logic                  iReset_n,
  fixed_order_selector_if.slave bus
);

  localparam int CNT_W = $clog2(BLOCK_SIZE + 1);

  sel_state_e              state_q, state_d;
  logic [2:0]              step_q, step_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    pipe_vld_q;
  logic [CNT_W-1:0]        pipe_idx_q;
  logic [SUM_W-1:0]        sum_q [ORDER_MAX+1];
  logic [SUM_W-1:0]        best_sum_q, out_sum_q, cand_sum;
  logic [2:0]              best_order_q, out_order_q;
  logic signed [RES_W-1:0] res [ORDER_MAX+1];
  logic                    ready, done, accept, last_sample, eligible, take;

  assign ready       = (state_q == ACCUM);
  assign done        = (state_q == DONE);
  assign accept      = bus.iValid && ready;
  assign last_sample = bus.iLast || (cnt_q == CNT_W'(BLOCK_SIZE - 1));

  fixed_residual_chain u_chain (
    .clk      (iClock),
    .rst_n    (iReset_n),
    .clear_i  (done),
    .valid_i  (accept),
    .sample_i (bus.iSample),
    .res_o    (res)
  );

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q <= ACCUM;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    unique case (state_q)
      ACCUM: begin
        step_d = '0;
        if (accept && last_sample) state_d = DRAIN;
      end
      DRAIN: begin
        if (step_q == 3'd1) begin
          state_d = COMPARE;
          step_d  = '0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      COMPARE: begin
        if (step_q == 3'(ORDER_MAX)) begin
          state_d = DONE;
          step_d  = '0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      DONE:    state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // NOTE: the five sums are plain registers, not a RAM, and must read zero
  // for the first block, so they take the asynchronous reset like the rest.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      cnt_q      <= '0;
      pipe_vld_q <= 1'b0;
      pipe_idx_q <= '0;
      for (int k = 0; k <= ORDER_MAX; k++) sum_q[k] <= '0;
    end else begin
      pipe_vld_q <= accept;
      pipe_idx_q <= cnt_q;
      if (done) begin
        cnt_q <= '0;
        for (int k = 0; k <= ORDER_MAX; k++) sum_q[k] <= '0;
      end else begin
        if (accept) cnt_q <= cnt_q + CNT_W'(1);
        // The first k samples of a block are warm-up for order k.
        if (pipe_vld_q) begin
          for (int k = 0; k <= ORDER_MAX; k++) begin
            if (pipe_idx_q >= CNT_W'(k)) sum_q[k] <= sum_q[k] + SUM_W'(abs_res(res[k]));
          end
        end
      end
    end
  end

  // During COMPARE, step_q is the candidate order and cnt_q the block length.
  always_comb begin
    cand_sum = '0;
    for (int k = 0; k <= ORDER_MAX; k++) begin
      if (step_q == 3'(k)) cand_sum = sum_q[k];
    end
    eligible = (step_q == 3'd0) || (cnt_q > CNT_W'(step_q));
    take     = eligible && ((step_q == 3'd0) || (cand_sum < best_sum_q));
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      best_sum_q   <= '0;
      best_order_q <= '0;
      out_sum_q    <= '0;
      out_order_q  <= '0;
    end else if (state_q == COMPARE) begin
      if (take) begin
        best_sum_q   <= cand_sum;
        best_order_q <= step_q;
      end
      if (step_q == 3'(ORDER_MAX)) begin
        out_sum_q   <= take ? cand_sum : best_sum_q;
        out_order_q <= take ? step_q   : best_order_q;
      end
    end
  end

  assign bus.oReady = ready;
  assign bus.oValid = done;
  assign bus.oOrder = out_order_q;
  assign bus.oSum   = out_sum_q;

endmodule
